// File: rtl/dyser_credit_tx_pkg.sv
// rtl/dyser_credit_tx_pkg.sv - shared dyser fabric word layout and tx FSM encodings
package dyser_credit_tx_pkg;

  localparam int META_W    = 2;
  localparam int VALID_BIT = 1;
  localparam int READY_BIT = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_CONF  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/dyser_credit_tx_if.sv
// rtl/dyser_credit_tx_if.sv - host, configuration and fabric signals of the credit transmitter
interface dyser_credit_tx_if
  import dyser_credit_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 2,
  parameter int FIFO_DEPTH = 4
);

  logic                              host_valid;
  logic [DATA_WIDTH-1:0]             host_data;
  logic                              host_pred;
  logic                              host_ready;
  logic                              conf_en;
  logic [DATA_WIDTH-1:0]             conf_data;
  logic [DATA_WIDTH+META_W-1:0]      d_out;
  logic                              c_in;
  logic [$clog2(CREDITS+1)-1:0]      credit_cnt;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  logic                              err_credit_ovf;

  modport slave (
    input  host_valid, host_data, host_pred, conf_en, conf_data, c_in,
    output host_ready, d_out, credit_cnt, fifo_count, err_credit_ovf
  );

  modport master (
    output host_valid, host_data, host_pred, conf_en, conf_data, c_in,
    input  host_ready, d_out, credit_cnt, fifo_count, err_credit_ovf
  );

endinterface

// File: rtl/dyser_tx_fifo.sv
// rtl/dyser_tx_fifo.sv - host-side word buffer, power-of-two depth, head visible combinationally
module dyser_tx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap by natural overflow because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/dyser_credit_tx.sv
// rtl/dyser_credit_tx.sv - credit-based dyser fabric transmitter with config passthrough
module dyser_credit_tx
  import dyser_credit_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  dyser_credit_tx_if.slave  tx
);

  localparam int               CW   = $clog2(CREDITS+1);
  localparam int               FW   = DATA_WIDTH + 1;
  localparam int               OW   = DATA_WIDTH + META_W;
  localparam logic [CW-1:0]    CMAX = CW'(CREDITS);

  tx_state_e                          r_state;
  tx_state_e                          w_next;
  logic [CW-1:0]                      r_credit;
  logic                               r_ovf;
  logic [OW-1:0]                      r_dout;
  logic [OW-1:0]                      w_word;
  logic [FW-1:0]                      w_head;
  logic                               w_full;
  logic                               w_empty;
  logic                               w_push;
  logic                               w_pop;
  logic                               w_cin;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    w_count;

  assign w_push = tx.host_valid && !w_full;
  // Configuration request takes priority over a pending send on the same edge
  assign w_pop  = (r_state == ST_RUN) && !tx.conf_en && !w_empty && (r_credit != '0);
  assign w_cin  = tx.c_in && (r_state != ST_CONF);

  dyser_tx_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({tx.host_data, tx.host_pred}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_next = r_state;
    if (r_state == ST_CONF) begin
      if (!tx.conf_en) w_next = ST_RUN;
    end else if (tx.conf_en) begin
      w_next = ST_CONF;
    end else if (r_state == ST_RUN) begin
      if (w_pop && (r_credit == CW'(1)) && !w_cin) w_next = ST_STALL;
    end else if (w_cin) begin
      w_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= CMAX;
      r_ovf    <= 1'b0;
    end else if (r_state == ST_CONF) begin
      if (!tx.conf_en) r_credit <= CMAX;
    end else if (w_pop && !w_cin) begin
      r_credit <= r_credit - CW'(1);
    end else if (w_cin && !w_pop) begin
      if (r_credit == CMAX) r_ovf    <= 1'b1;
      else                  r_credit <= r_credit + CW'(1);
    end
  end

  always_comb begin
    w_word            = '0;
    w_word[OW-1:2]    = w_head[FW-1:1];
    w_word[VALID_BIT] = w_head[0];
    w_word[READY_BIT] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_dout <= '0;
    else if (w_pop) r_dout <= w_word;
    else            r_dout <= '0;
  end

  assign tx.d_out          = (r_state == ST_CONF) ? {tx.conf_data, 2'b00} : r_dout;
  assign tx.host_ready     = !w_full;
  assign tx.credit_cnt     = r_credit;
  assign tx.fifo_count     = w_count;
  assign tx.err_credit_ovf = r_ovf;

endmodule

// File: tb/tb_dyser_credit_tx.sv
// tb/tb_dyser_credit_tx.sv - directed self-checking bench for dyser_credit_tx
module tb_dyser_credit_tx;
  import dyser_credit_tx_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dyser_credit_tx_if #(.DATA_WIDTH(32), .CREDITS(2), .FIFO_DEPTH(4)) bus ();

  dyser_credit_tx #(.DATA_WIDTH(32), .CREDITS(2), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic p);
    bus.host_valid = 1'b1;
    bus.host_data  = d;
    bus.host_pred  = p;
    tick();
    bus.host_valid = 1'b0;
  endtask

  function automatic logic [63:0] word(input logic [31:0] d, input logic p);
    return 64'({d, p, 1'b1});
  endfunction

  logic [31:0] wq [7];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.host_pred  = 1'b0;
    bus.conf_en    = 1'b0;
    bus.conf_data  = '0;
    bus.c_in       = 1'b0;
    for (int i = 0; i < 7; i++) wq[i] = 32'h1000_0000 + 32'(i * 17);

    repeat (2) tick();
    chk("rst_dout",   64'(bus.d_out), 64'd0);
    chk("rst_credit", 64'(bus.credit_cnt), 64'd2);
    chk("rst_count",  64'(bus.fifo_count), 64'd0);
    chk("rst_ovf",    64'(bus.err_credit_ovf), 64'd0);
    chk("rst_ready",  64'(bus.host_ready), 64'd1);
    rst = 1'b0;

    // single word: written on edge 1, sent on edge 2
    push(32'hA5A5A5A5, 1'b1);
    chk("single_nobypass", 64'(bus.d_out), 64'd0);
    tick();
    chk("single_dout",   64'(bus.d_out), word(32'hA5A5A5A5, 1'b1));
    chk("single_credit", 64'(bus.credit_cnt), 64'd1);
    tick();
    chk("single_onecyc", 64'(bus.d_out), 64'd0);

    // four words back-to-back, two credits
    do_reset();
    bus.host_valid = 1'b1;
    bus.host_pred  = 1'b0;
    bus.host_data  = wq[0]; tick();
    bus.host_data  = wq[1]; tick();
    chk("b2b_w0", 64'(bus.d_out), word(wq[0], 1'b0));
    bus.host_data  = wq[2]; tick();
    chk("b2b_w1", 64'(bus.d_out), word(wq[1], 1'b0));
    chk("b2b_credit0", 64'(bus.credit_cnt), 64'd0);
    chk("b2b_stall", 64'(dut.r_state), 64'(ST_STALL));
    bus.host_data  = wq[3]; tick();
    bus.host_valid = 1'b0;
    chk("b2b_idle",  64'(bus.d_out), 64'd0);
    chk("b2b_count", 64'(bus.fifo_count), 64'd2);
    bus.c_in = 1'b1; tick(); bus.c_in = 1'b0;
    chk("cin_credit1", 64'(bus.credit_cnt), 64'd1);
    chk("cin_run",     64'(dut.r_state), 64'(ST_RUN));
    tick();
    chk("cin_w2",      64'(bus.d_out), word(wq[2], 1'b0));
    chk("cin_credit0", 64'(bus.credit_cnt), 64'd0);

    // fill while starved of credits
    push(wq[4], 1'b1);
    push(wq[5], 1'b0);
    push(wq[6], 1'b1);
    chk("full_count", 64'(bus.fifo_count), 64'd4);
    chk("full_ready", 64'(bus.host_ready), 64'd0);
    push(32'hDEADBEEF, 1'b0);
    chk("full_reject", 64'(bus.fifo_count), 64'd4);
    for (int i = 3; i < 7; i++) begin
      bus.c_in = 1'b1; tick(); bus.c_in = 1'b0;
      tick();
      chk($sformatf("drain_w%0d", i), 64'(bus.d_out), word(wq[i], (i == 4 || i == 6)));
    end
    chk("drain_empty", 64'(bus.fifo_count), 64'd0);

    // send and credit return on the same edge
    do_reset();
    bus.host_valid = 1'b1;
    bus.host_pred  = 1'b1;
    bus.host_data  = 32'h0000_00C0; tick();
    bus.host_data  = 32'h0000_00C1; tick();
    bus.host_valid = 1'b0;
    chk("same_credit1", 64'(bus.credit_cnt), 64'd1);
    bus.c_in = 1'b1; tick(); bus.c_in = 1'b0;
    chk("same_dout",   64'(bus.d_out), word(32'h0000_00C1, 1'b1));
    chk("same_credit", 64'(bus.credit_cnt), 64'd1);
    chk("same_run",    64'(dut.r_state), 64'(ST_RUN));

    // credit overflow, sticky until reset
    bus.c_in = 1'b1; tick();
    chk("ovf_pre_credit", 64'(bus.credit_cnt), 64'd2);
    chk("ovf_pre_flag",   64'(bus.err_credit_ovf), 64'd0);
    tick(); bus.c_in = 1'b0;
    chk("ovf_credit", 64'(bus.credit_cnt), 64'd2);
    chk("ovf_flag",   64'(bus.err_credit_ovf), 64'd1);
    repeat (3) tick();
    chk("ovf_sticky", 64'(bus.err_credit_ovf), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(bus.err_credit_ovf), 64'd0);

    // configuration mode with buffered words
    push(32'h0000_0055, 1'b0);
    tick();
    chk("conf_pre_credit", 64'(bus.credit_cnt), 64'd1);
    bus.conf_en   = 1'b1;
    bus.conf_data = 32'h12345678;
    tick();
    chk("conf_dout", 64'(bus.d_out), 64'({32'h12345678, 2'b00}));
    push(32'h0000_0A01, 1'b1);
    push(32'h0000_0A02, 1'b0);
    chk("conf_nopop", 64'(bus.fifo_count), 64'd2);
    bus.c_in = 1'b1; tick(); bus.c_in = 1'b0;
    chk("conf_cin_ignored", 64'(bus.credit_cnt), 64'd1);
    bus.conf_data = 32'h0BADF00D;
    #1;
    chk("conf_comb", 64'(bus.d_out), 64'({32'h0BADF00D, 2'b00}));
    bus.conf_en = 1'b0;
    tick();
    chk("conf_reload", 64'(bus.credit_cnt), 64'd2);
    chk("conf_ovf_kept", 64'(bus.err_credit_ovf), 64'd0);
    chk("conf_exit_dout", 64'(bus.d_out), 64'd0);
    tick();
    chk("conf_z0", 64'(bus.d_out), word(32'h0000_0A01, 1'b1));
    tick();
    chk("conf_z1", 64'(bus.d_out), word(32'h0000_0A02, 1'b0));
    chk("conf_credit0", 64'(bus.credit_cnt), 64'd0);

    // asynchronous reset mid-transfer
    do_reset();
    push(32'h0000_0B01, 1'b1);
    push(32'h0000_0B02, 1'b1);
    chk("ar_pre_dout", 64'(bus.d_out), word(32'h0000_0B01, 1'b1));
    rst = 1'b1;
    #1;
    chk("ar_dout",   64'(bus.d_out), 64'd0);
    chk("ar_count",  64'(bus.fifo_count), 64'd0);
    chk("ar_credit", 64'(bus.credit_cnt), 64'd2);
    tick();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dyser_credit_tx.md
DYSER_CREDIT_TX -- requirements
Module: dyser_credit_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload bits per fabric word.
REQ-002 Parameter CREDITS, default 2: credits available at downstream stage after reset or configuration.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two): host-side buffer entries.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 host_valid  input  1: host offers a word this cycle.
REQ-007 host_data  input  DATA_WIDTH: payload offered by host.
REQ-008 host_pred  input  1: predicate/valid flag carried with payload.
REQ-009 host_ready  output  1: buffer can accept; equals not-full.
REQ-010 conf_en  input  1: configuration mode.
REQ-011 conf_data  input  DATA_WIDTH: configuration word driven onto fabric while conf_en=1.
REQ-012 d_out  output  DATA_WIDTH+2: fabric word {data, valid, ready}; bit0 = word-present strobe, bit1 = predicate flag.
REQ-013 c_in  input  1: one-cycle credit-return pulse from downstream stage.
REQ-014 credit_cnt  output  clog2(CREDITS+1): current credits held.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH+1): buffered words.
REQ-016 err_credit_ovf  output  1: sticky credit-overflow flag.

Function
REQ-017 Host transfer occurs on any edge where host_valid=1 and host_ready=1; word {host_data, host_pred} written at tail.
REQ-018 FSM states RUN, STALL, CONF; reset state RUN.
REQ-019 RUN: on an edge with fifo_count>0 and credit_cnt>0, pop head and register d_out={data, pred, 1'b1} for exactly one cycle; else d_out=0.
REQ-020 RUN->STALL when a send leaves credit_cnt=0 with no concurrent c_in; STALL->RUN on edge with c_in=1; STALL drives d_out=0.
REQ-021 Any state->CONF when conf_en=1; CONF drives d_out={conf_data, 2'b00} combinationally, no pops, host writes still accepted.
REQ-022 CONF->RUN on first edge with conf_en=0; credit_cnt reloaded to CREDITS on that edge, err_credit_ovf unchanged.
REQ-023 Latency: word written at edge k appears on d_out no earlier than after edge k+1 (no bypass); back-to-back sends at one word/cycle while credits last.
REQ-024 Credit arithmetic: send only: -1; c_in only: +1; send and c_in same edge: unchanged; c_in in CONF ignored.
REQ-025 c_in with credit_cnt=CREDITS and no concurrent send: counter saturates at CREDITS, err_credit_ovf set, cleared only by reset.
REQ-026 FIFO read/write pointers wrap modulo FIFO_DEPTH; simultaneous push and pop when full is allowed only if pop occurs (host_ready reflects pre-edge count, so full blocks push).
REQ-027 Simultaneous push and pop leaves fifo_count unchanged; pop from empty never occurs.
REQ-028 Word order on d_out equals host acceptance order.

Reset
REQ-029 While rst=1: state RUN, d_out=0, credit_cnt=CREDITS, fifo_count=0, pointers 0, err_credit_ovf=0, host_ready=1.
REQ-030 Reset mid-transfer discards buffered words and in-flight d_out immediately (asynchronous).

Structure
REQ-031 Path-width, metabit positions (VALID=1, READY=0) and FSM state encodings live in the shared dyser configuration package/include.
REQ-032 FIFO is one sub-module, dyser_tx_fifo (parameterised DATA_WIDTH+1, FIFO_DEPTH); FSM and credit counter in top.

Verification
REQ-033 Reset, push 0xA5A5A5A5 pred=1, no c_in -> after 2 edges d_out={0xA5A5A5A5,1,1} for one cycle, credit_cnt=1.
REQ-034 Push 4 words, no c_in -> exactly 2 sends, state STALL, fifo_count=2; pulse c_in once -> one more send, credit_cnt returns 0.
REQ-035 Fill 4 words with credits=0 -> host_ready=0, 5th host_valid not accepted; c_in then releases words in order.
REQ-036 Send and c_in on same edge at credit_cnt=1 -> credit_cnt stays 1.
REQ-037 c_in at credit_cnt=2, idle -> err_credit_ovf=1, credit_cnt=2; persists until rst.
REQ-038 conf_en=1 with conf_data=0x12345678 and 2 words buffered -> d_out={0x12345678,0,0}, no pops; conf_en=0 -> credit_cnt=2, both words sent in order.
